aq_lsu_amo_stb_ctrl: RTL and testbench
======================================

AQ_LSU_AMO_STB_CTRL -- requirements
Module: aq_lsu_amo_stb_ctrl

Interface
REQ-001 SHALL have port forever_cpuclk, in, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port cpurst, in, 1: reset, synchronous and active-high.
REQ-003 SHALL have ports alloc_vld in 1, alloc_id in 2, alloc_data in 64: allocate an AMO entry holding the store operand (src1).
REQ-004 SHALL have port stb_amo_free out 4: per-entry IDLE vector.
REQ-005 SHALL have ports da_amo_src_vld in 1, da_amo_stb_id in 2: the ALU has consumed the entry's operand this cycle.
REQ-006 SHALL have port stb_amo_alu_src1 out 64: the data of entry da_amo_stb_id, combinational.
REQ-007 SHALL have ports amo_alu_stb_rst_vld in 1, amo_alu_stb_id in 2, amo_alu_stb_rst in 64: the registered ALU result return.
REQ-008 SHALL have ports stb_wb_req_vld out 1, stb_wb_id out 2, stb_wb_data out 64, wb_stb_grant in 1: result write-back valid/ready handshake.
REQ-009 SHALL have port amo_flush in 1: cancel entries not yet issued.
REQ-010 SHALL have port amo_stb_err out 1: sticky protocol-violation flag.

Function
REQ-011 SHALL keep 4 entries, each with a state (IDLE, WAIT_SRC, WAIT_RST, RDY) and 64-bit data.
REQ-012 SHALL move an entry IDLE->WAIT_SRC on alloc_vld and write alloc_data, only if that entry was IDLE at the start of the cycle.
REQ-013 SHALL move an entry WAIT_SRC->WAIT_RST on da_amo_src_vld for that id; stb_amo_alu_src1 reflects the data held at the start of the cycle.
REQ-014 SHALL move an entry WAIT_RST->RDY on amo_alu_stb_rst_vld for that id and overwrite its data with amo_alu_stb_rst.
REQ-015 SHALL raise stb_wb_req_vld the cycle after an entry enters RDY (registered state); there is no combinational rst-to-req path.
REQ-016 SHALL pick among RDY entries round-robin from pointer wb_ptr (reset 0); after each grant, wb_ptr = granted id + 1 mod 4 (wraps 3->0).
REQ-017 SHALL hold stb_wb_id and stb_wb_data stable while stb_wb_req_vld=1 and wb_stb_grant=0.
REQ-018 SHALL move the granted entry RDY->IDLE on stb_wb_req_vld && wb_stb_grant; that entry is free for allocation from the next cycle.
REQ-019 SHALL return every WAIT_SRC entry to IDLE on amo_flush; WAIT_RST and RDY entries complete normally.
REQ-020 SHALL give amo_flush priority over da_amo_src_vld when both hit the same entry: the entry goes IDLE and a later result for it is a violation.
REQ-021 SHALL apply events on different entries in the same cycle independently: alloc, issue, result and grant all take effect.
REQ-022 SHALL classify as violations: alloc to a non-IDLE entry, issue to a non-WAIT_SRC entry, and result to a non-WAIT_RST entry.
REQ-023 SHALL leave entry state and data unchanged on any violation.

Reset
REQ-024 SHALL on cpurst put all entries in IDLE, clear wb_ptr, and drive stb_amo_free=4'b1111, stb_wb_req_vld=0, stb_wb_id=0, stb_wb_data=0, amo_stb_err=0.
REQ-025 SHALL discard any in-flight result or grant when cpurst is asserted mid-operation; cpurst overrides every other input.
REQ-026 SHALL leave entry data unreset (don't-care while IDLE); stb_wb_data is gated to 0 when no request is pending.

Configuration
REQ-027 SHALL, with AQ_LSU_AMO_PROT_CHK_EN defined, set amo_stb_err sticky on any REQ-022 violation; it clears only on cpurst.
REQ-028 SHALL, without AQ_LSU_AMO_PROT_CHK_EN, tie amo_stb_err to 0 and omit the check logic; violations are still ignored per REQ-023.

Structure
REQ-029 SHALL place the entry-state encoding (IDLE=2'b00, WAIT_SRC=2'b01, WAIT_RST=2'b10, RDY=2'b11), the entry count 4 and the data width 64 in a shared package aq_lsu_amo_pkg.
REQ-030 SHALL implement one sub-module, aq_lsu_amo_stb_entry (one state machine plus its data register), instantiated 4 times; arbitration stays in the top.

Verification
REQ-031 SHALL cover: alloc id1 data 0x5; issue id1 -> src1=0x5; result id1 0x9 -> next cycle req_vld=1, id=1, data=0x9; grant -> free[1]=1.
REQ-032 SHALL cover: entries 0, 2 and 3 RDY, wb_ptr=3 -> grant order 3, 0, 2.
REQ-033 SHALL cover: req pending with grant held 0 for 5 cycles -> id and data unchanged throughout.
REQ-034 SHALL cover: entries 0 (WAIT_SRC) and 1 (WAIT_RST), flush -> entry 0 IDLE; result id1 0xA still produces req id1 data 0xA.
REQ-035 SHALL cover: result for IDLE entry 2 -> state unchanged; amo_stb_err=1 with macro, 0 without.
REQ-036 SHALL cover: cpurst asserted in the same cycle as a result and a grant -> next cycle all free=4'b1111, req_vld=0.

Source files
------------

// File: rtl/aq_lsu_amo_pkg.sv
// Shared definitions for the LSU AMO store-buffer control: entry count,
// data width and the per-entry state encoding.
package aq_lsu_amo_pkg;

    localparam int AMO_ENTRY_NUM = 4;
    localparam int AMO_ID_W      = 2;
    localparam int AMO_DATA_W    = 64;

    typedef enum logic [1:0] {
        AMO_IDLE     = 2'b00,
        AMO_WAIT_SRC = 2'b01,
        AMO_WAIT_RST = 2'b10,
        AMO_RDY      = 2'b11
    } amo_state_e;

endpackage

// File: rtl/aq_lsu_amo_stb_entry.sv
// One AMO store-buffer entry: state machine plus its operand/result register.
// The violation output exists only when AQ_LSU_AMO_PROT_CHK_EN is defined.
module aq_lsu_amo_stb_entry
    import aq_lsu_amo_pkg::*;
(
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  alloc_hit,
    input  logic [AMO_DATA_W-1:0] alloc_data,
    input  logic                  issue_hit,
    input  logic                  flush,
    input  logic                  rst_hit,
    input  logic [AMO_DATA_W-1:0] rst_data,
    input  logic                  grant_hit,
`ifdef AQ_LSU_AMO_PROT_CHK_EN
    output logic                  viol,
`endif
    output amo_state_e            state,
    output logic [AMO_DATA_W-1:0] data
);

    // Every event is judged against the state held at the start of the cycle,
    // so an illegal event simply falls through the case and changes nothing.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state <= AMO_IDLE;
        end else begin
            case (state)
                AMO_IDLE:     if (alloc_hit) state <= AMO_WAIT_SRC;
                AMO_WAIT_SRC: begin
                    if (flush)          state <= AMO_IDLE;
                    else if (issue_hit) state <= AMO_WAIT_RST;
                end
                AMO_WAIT_RST: if (rst_hit)   state <= AMO_RDY;
                AMO_RDY:      if (grant_hit) state <= AMO_IDLE;
                default:      state <= AMO_IDLE;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (alloc_hit && state == AMO_IDLE) begin
            data <= alloc_data;
        end else if (rst_hit && state == AMO_WAIT_RST) begin
            data <= rst_data;
        end
    end

`ifdef AQ_LSU_AMO_PROT_CHK_EN
    assign viol = (alloc_hit && state != AMO_IDLE)
                | (issue_hit && state != AMO_WAIT_SRC)
                | (rst_hit   && state != AMO_WAIT_RST);
`endif

endmodule

// File: rtl/aq_lsu_amo_stb_ctrl.sv
// AMO store-buffer control: four entries, round-robin result write-back.
// Define AQ_LSU_AMO_PROT_CHK_EN to enable the sticky protocol-violation flag.
module aq_lsu_amo_stb_ctrl
    import aq_lsu_amo_pkg::*;
(
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  alloc_vld,
    input  logic [AMO_ID_W-1:0]   alloc_id,
    input  logic [AMO_DATA_W-1:0] alloc_data,
    output logic [AMO_ENTRY_NUM-1:0] stb_amo_free,
    input  logic                  da_amo_src_vld,
    input  logic [AMO_ID_W-1:0]   da_amo_stb_id,
    output logic [AMO_DATA_W-1:0] stb_amo_alu_src1,
    input  logic                  amo_alu_stb_rst_vld,
    input  logic [AMO_ID_W-1:0]   amo_alu_stb_id,
    input  logic [AMO_DATA_W-1:0] amo_alu_stb_rst,
    output logic                  stb_wb_req_vld,
    output logic [AMO_ID_W-1:0]   stb_wb_id,
    output logic [AMO_DATA_W-1:0] stb_wb_data,
    input  logic                  wb_stb_grant,
    input  logic                  amo_flush,
    output logic                  amo_stb_err
);

    amo_state_e              entry_state [AMO_ENTRY_NUM];
    logic [AMO_DATA_W-1:0]   entry_data  [AMO_ENTRY_NUM];
    logic [AMO_ENTRY_NUM-1:0] entry_rdy;
`ifdef AQ_LSU_AMO_PROT_CHK_EN
    logic [AMO_ENTRY_NUM-1:0] entry_viol;
`endif

    logic [AMO_ID_W-1:0] wb_ptr;
    logic                hold_vld_q;
    logic [AMO_ID_W-1:0] hold_id_q;
    logic                pick_vld;
    logic [AMO_ID_W-1:0] pick_id;
    logic                wb_fire;

    function automatic logic [AMO_ID_W:0] rr_pick(input logic [AMO_ENTRY_NUM-1:0] rdy,
                                                   input logic [AMO_ID_W-1:0] ptr);
        logic [AMO_ID_W-1:0] idx;
        rr_pick = '0;
        for (int k = AMO_ENTRY_NUM - 1; k >= 0; k--) begin
            idx = ptr + AMO_ID_W'(k);
            if (rdy[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    for (genvar i = 0; i < AMO_ENTRY_NUM; i++) begin : g_entry
        aq_lsu_amo_stb_entry u_entry (
            .forever_cpuclk (forever_cpuclk),
            .cpurst         (cpurst),
            .alloc_hit      (alloc_vld && alloc_id == AMO_ID_W'(i)),
            .alloc_data     (alloc_data),
            .issue_hit      (da_amo_src_vld && da_amo_stb_id == AMO_ID_W'(i)),
            .flush          (amo_flush),
            .rst_hit        (amo_alu_stb_rst_vld && amo_alu_stb_id == AMO_ID_W'(i)),
            .rst_data       (amo_alu_stb_rst),
            .grant_hit      (wb_fire && stb_wb_id == AMO_ID_W'(i)),
`ifdef AQ_LSU_AMO_PROT_CHK_EN
            .viol           (entry_viol[i]),
`endif
            .state          (entry_state[i]),
            .data           (entry_data[i])
        );
        assign stb_amo_free[i] = (entry_state[i] == AMO_IDLE);
        assign entry_rdy[i]    = (entry_state[i] == AMO_RDY);
    end

    assign stb_amo_alu_src1 = entry_data[da_amo_stb_id];

    // Request is driven from registered entry state only; once offered and not
    // granted, the chosen id is latched so a newly ready entry cannot steal it.
    assign {pick_vld, pick_id} = rr_pick(entry_rdy, wb_ptr);
    assign stb_wb_req_vld = hold_vld_q | pick_vld;
    assign stb_wb_id      = hold_vld_q ? hold_id_q : pick_id;
    assign stb_wb_data    = stb_wb_req_vld ? entry_data[stb_wb_id] : '0;
    assign wb_fire        = stb_wb_req_vld & wb_stb_grant;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            wb_ptr     <= '0;
            hold_vld_q <= 1'b0;
            hold_id_q  <= '0;
        end else begin
            if (wb_fire) wb_ptr <= stb_wb_id + AMO_ID_W'(1);
            hold_vld_q <= stb_wb_req_vld & ~wb_stb_grant;
            if (stb_wb_req_vld && !wb_stb_grant) hold_id_q <= stb_wb_id;
        end
    end

`ifdef AQ_LSU_AMO_PROT_CHK_EN
    logic err_q;
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst)           err_q <= 1'b0;
        else if (|entry_viol) err_q <= 1'b1;
    end
    assign amo_stb_err = err_q;
`else
    assign amo_stb_err = 1'b0;
`endif

endmodule

// File: tb/tb_aq_lsu_amo_stb_ctrl.sv
// Directed self-checking bench for aq_lsu_amo_stb_ctrl (either build of
// AQ_LSU_AMO_PROT_CHK_EN).
module tb_aq_lsu_amo_stb_ctrl;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst;
    logic        alloc_vld;
    logic [1:0]  alloc_id;
    logic [63:0] alloc_data;
    logic [3:0]  stb_amo_free;
    logic        da_amo_src_vld;
    logic [1:0]  da_amo_stb_id;
    logic [63:0] stb_amo_alu_src1;
    logic        amo_alu_stb_rst_vld;
    logic [1:0]  amo_alu_stb_id;
    logic [63:0] amo_alu_stb_rst;
    logic        stb_wb_req_vld;
    logic [1:0]  stb_wb_id;
    logic [63:0] stb_wb_data;
    logic        wb_stb_grant;
    logic        amo_flush;
    logic        amo_stb_err;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef AQ_LSU_AMO_PROT_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    aq_lsu_amo_stb_ctrl dut (
        .forever_cpuclk      (forever_cpuclk),
        .cpurst              (cpurst),
        .alloc_vld           (alloc_vld),
        .alloc_id            (alloc_id),
        .alloc_data          (alloc_data),
        .stb_amo_free        (stb_amo_free),
        .da_amo_src_vld      (da_amo_src_vld),
        .da_amo_stb_id       (da_amo_stb_id),
        .stb_amo_alu_src1    (stb_amo_alu_src1),
        .amo_alu_stb_rst_vld (amo_alu_stb_rst_vld),
        .amo_alu_stb_id      (amo_alu_stb_id),
        .amo_alu_stb_rst     (amo_alu_stb_rst),
        .stb_wb_req_vld      (stb_wb_req_vld),
        .stb_wb_id           (stb_wb_id),
        .stb_wb_data         (stb_wb_data),
        .wb_stb_grant        (wb_stb_grant),
        .amo_flush           (amo_flush),
        .amo_stb_err         (amo_stb_err)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clr();
        cpurst = 0; alloc_vld = 0; alloc_id = 0; alloc_data = 0;
        da_amo_src_vld = 0; da_amo_stb_id = 0;
        amo_alu_stb_rst_vld = 0; amo_alu_stb_id = 0; amo_alu_stb_rst = 0;
        wb_stb_grant = 0; amo_flush = 0;
    endtask

    task automatic step();
        @(posedge forever_cpuclk);
        #1;
        clr();
    endtask

    task automatic do_alloc(input logic [1:0] id, input logic [63:0] d);
        alloc_vld = 1; alloc_id = id; alloc_data = d; step();
    endtask

    task automatic do_issue(input logic [1:0] id);
        da_amo_src_vld = 1; da_amo_stb_id = id; step();
    endtask

    task automatic do_result(input logic [1:0] id, input logic [63:0] d);
        amo_alu_stb_rst_vld = 1; amo_alu_stb_id = id; amo_alu_stb_rst = d; step();
    endtask

    task automatic do_grant();
        wb_stb_grant = 1; step();
    endtask

    initial begin
        clr();
        cpurst = 1;
        @(posedge forever_cpuclk); #1;
        cpurst = 1;
        step();
        chk("rst_free", stb_amo_free, 4'b1111);
        chk("rst_req", stb_wb_req_vld, 0);
        chk("rst_id", stb_wb_id, 0);
        chk("rst_data", stb_wb_data, 0);
        chk("rst_err", amo_stb_err, 0);

        // Basic flow on entry 1
        do_alloc(1, 64'h5);
        chk("alloc_free", stb_amo_free, 4'b1101);
        da_amo_src_vld = 1; da_amo_stb_id = 1; #1;
        chk("src1", stb_amo_alu_src1, 64'h5);
        step();
        amo_alu_stb_rst_vld = 1; amo_alu_stb_id = 1; amo_alu_stb_rst = 64'h9; #1;
        chk("no_comb_req", stb_wb_req_vld, 0);
        step();
        chk("flow_req", stb_wb_req_vld, 1);
        chk("flow_id", stb_wb_id, 1);
        chk("flow_data", stb_wb_data, 64'h9);
        do_grant();
        chk("flow_free", stb_amo_free, 4'b1111);
        chk("flow_req_off", stb_wb_req_vld, 0);
        chk("flow_data_gate", stb_wb_data, 0);

        // Round robin: move pointer to 3, then entries 3,0,2 ready
        do_alloc(2, 64'h22); do_issue(2); do_result(2, 64'h22); do_grant();
        do_alloc(0, 64'h0); do_alloc(2, 64'h0); do_alloc(3, 64'h0);
        do_issue(0); do_issue(2); do_issue(3);
        do_result(3, 64'hA3); do_result(0, 64'hA0); do_result(2, 64'hA2);
        chk("rr1_id", stb_wb_id, 3);
        chk("rr1_data", stb_wb_data, 64'hA3);
        do_grant();
        chk("rr2_id", stb_wb_id, 0);
        chk("rr2_data", stb_wb_data, 64'hA0);
        do_grant();
        chk("rr3_id", stb_wb_id, 2);
        chk("rr3_data", stb_wb_data, 64'hA2);
        do_grant();
        chk("rr_free", stb_amo_free, 4'b1111);

        // Hold stability: entry 1 pending, entry 0 becomes ready (ptr=3 prefers 0)
        do_alloc(0, 64'h55); do_issue(0); do_alloc(1, 64'h0); do_issue(1);
        do_result(1, 64'h77);
        for (int c = 0; c < 5; c++) begin
            chk("hold_vld", stb_wb_req_vld, 1);
            chk("hold_id", stb_wb_id, 1);
            chk("hold_data", stb_wb_data, 64'h77);
            if (c == 0) begin
                amo_alu_stb_rst_vld = 1; amo_alu_stb_id = 0; amo_alu_stb_rst = 64'h66;
            end
            step();
        end
        do_grant();
        chk("hold_next_id", stb_wb_id, 0);
        chk("hold_next_data", stb_wb_data, 64'h66);
        do_grant();

        // Flush: entry 0 WAIT_SRC dropped, entry 1 WAIT_RST completes
        do_alloc(0, 64'h11); do_alloc(1, 64'h12); do_issue(1);
        amo_flush = 1; step();
        chk("flush_free", stb_amo_free, 4'b1101);
        do_result(1, 64'hA);
        chk("flush_req", stb_wb_req_vld, 1);
        chk("flush_id", stb_wb_id, 1);
        chk("flush_data", stb_wb_data, 64'hA);
        do_grant();
        chk("flush_err", amo_stb_err, 0);

        // Result to IDLE entry 2
        do_result(2, 64'hBAD);
        chk("viol_free", stb_amo_free, 4'b1111);
        chk("viol_req", stb_wb_req_vld, 0);
        chk("viol_err", amo_stb_err, EXP_ERR);

        // Flush wins over issue on the same entry; the later result is ignored
        do_alloc(2, 64'h2);
        amo_flush = 1; da_amo_src_vld = 1; da_amo_stb_id = 2; step();
        chk("fprio_free", stb_amo_free, 4'b1111);
        do_result(2, 64'hC);
        chk("fprio_free2", stb_amo_free, 4'b1111);
        chk("fprio_req", stb_wb_req_vld, 0);

        // Independent same-cycle events, then reset against result and grant
        do_alloc(3, 64'h33);
        alloc_vld = 1; alloc_id = 0; alloc_data = 64'h44;
        da_amo_src_vld = 1; da_amo_stb_id = 3; step();
        amo_alu_stb_rst_vld = 1; amo_alu_stb_id = 3; amo_alu_stb_rst = 64'h3E;
        da_amo_src_vld = 1; da_amo_stb_id = 0; step();
        chk("multi_free", stb_amo_free, 4'b0110);
        chk("multi_id", stb_wb_id, 3);
        chk("multi_data", stb_wb_data, 64'h3E);
        cpurst = 1; wb_stb_grant = 1;
        amo_alu_stb_rst_vld = 1; amo_alu_stb_id = 0; amo_alu_stb_rst = 64'h99;
        step();
        chk("mrst_free", stb_amo_free, 4'b1111);
        chk("mrst_req", stb_wb_req_vld, 0);
        chk("mrst_id", stb_wb_id, 0);
        chk("mrst_data", stb_wb_data, 0);
        chk("mrst_err", amo_stb_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
